// File: rtl/ksa_byte_sequencer_if.sv
// ---------------------------------------------------------------------------
// ksa_byte_sequencer_if
//
// Operand-request and result-return bundle for ksa_byte_sequencer.
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clock edge where the producer's valid and
//   the consumer's ready are both high. A producer that raises valid keeps
//   its payload stable until that transfer edge. Ready and valid coming out
//   of the sequencer are decoded from its state register only, so neither
//   one depends combinationally on the opposite side's valid or ready.
//
// Signals:
//   i_valid  operand request valid            (master -> slave)
//   o_ready  sequencer can accept operands     (slave  -> master)
//   i_a/i_b  operands, 8*NBYTES bits each      (master -> slave)
//   i_cin    carry-in for the whole word       (master -> slave)
//   o_valid  result valid                      (slave  -> master)
//   i_ready  downstream accepts the result     (master -> slave)
//   o_sum    sum, 8*NBYTES bits                (slave  -> master)
//   o_cout   carry out of the top byte         (slave  -> master)
//   o_busy   operation in flight (RUN or DONE) (slave  -> master)
// ---------------------------------------------------------------------------
interface ksa_byte_sequencer_if #(
   parameter int NBYTES = 4
);
   logic                  i_valid;
   logic                  o_ready;
   logic [8*NBYTES-1:0]   i_a;
   logic [8*NBYTES-1:0]   i_b;
   logic                  i_cin;
   logic                  o_valid;
   logic                  i_ready;
   logic [8*NBYTES-1:0]   o_sum;
   logic                  o_cout;
   logic                  o_busy;

   // Upstream/downstream environment that drives requests and takes results.
   modport master (
      output i_valid, i_a, i_b, i_cin, i_ready,
      input  o_ready, o_valid, o_sum, o_cout, o_busy
   );

   // The sequencer itself.
   modport slave (
      input  i_valid, i_a, i_b, i_cin, i_ready,
      output o_ready, o_valid, o_sum, o_cout, o_busy
   );
endinterface

// File: rtl/ksa_byte_sequencer.sv
// ---------------------------------------------------------------------------
// ksa_byte_sequencer.sv
//
// Contains:
//   ksa_top_compact    - 8-bit Kogge-Stone adder with carry-in.
//   ksa_byte_sequencer - multi-cycle wide adder: captures two NBYTES-byte
//                        operands, streams them LSB byte first through one
//                        ksa_top_compact, recirculating the carry through a
//                        register, then presents the full-width sum.
//
// ksa_top_compact ports:
//   c0       carry-in
//   i_a,i_b  8-bit addends
//   o_s      8-bit sum
//   o_carry  carry out of bit 7
//
// ksa_byte_sequencer ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        ksa_byte_sequencer_if.slave: operand request / result return
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
// ---------------------------------------------------------------------------

module ksa_top_compact (
   input  logic       c0,
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_s,
   output logic       o_carry
);
   logic [7:0] p0;
   logic [7:0] g0;
   logic [7:0] g1;
   logic [7:0] p1;
   logic [7:0] g2;
   logic [7:0] p2;
   logic [7:0] g3;
   logic [7:0] carry_in;

   assign p0 = i_a ^ i_b;

   // The carry-in is folded into the bit-0 generate, so every prefix
   // generate below is an absolute carry out of its bit position and the
   // zero shifted into the low propagate bits is harmless.
   assign g0 = {i_a[7:1] & i_b[7:1], (i_a[0] & i_b[0]) | (p0[0] & c0)};

   // Prefix levels with span 1, 2, 4.
   assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
   assign p1 = p0 & {p0[6:0], 1'b0};

   assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
   assign p2 = p1 & {p1[5:0], 2'b00};

   assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});

   assign carry_in = {g3[6:0], c0};
   assign o_s      = p0 ^ carry_in;
   assign o_carry  = g3[7];
endmodule

module ksa_byte_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   ksa_byte_sequencer_if.slave     bus,
   output logic [1:0]              dbg_state
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state;
   state_t         state_d;

   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [W-1:0]   sum_q;
   logic           cy_q;
   logic           cout_q;
   logic [IW-1:0]  idx_q;

   logic           accept;
   logic           last_byte;
   logic           add_c0;
   logic [7:0]     add_a;
   logic [7:0]     add_b;
   logic [7:0]     add_s;
   logic           add_carry;

   ksa_top_compact u_ksa (
      .c0      (add_c0),
      .i_a     (add_a),
      .i_b     (add_b),
      .o_s     (add_s),
      .o_carry (add_carry)
   );

   // Next-state and adder-input decode. Outside RUN the adder inputs are
   // parked at zero so the adder does not toggle on operand-bus activity.
   always_comb begin
      state_d   = state;
      accept    = 1'b0;
      last_byte = (idx_q == LAST_IDX);
      add_c0    = 1'b0;
      add_a     = 8'h00;
      add_b     = 8'h00;
      case (state)
         IDLE: begin
            if (bus.i_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            add_c0 = cy_q;
            add_a  = a_q[{idx_q, 3'b000} +: 8];
            add_b  = b_q[{idx_q, 3'b000} +: 8];
            if (last_byte) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.i_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sum_q  <= '0;
         cy_q   <= 1'b0;
         cout_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            // Operands are sampled only here; later bus changes are ignored.
            a_q   <= bus.i_a;
            b_q   <= bus.i_b;
            cy_q  <= bus.i_cin;
            idx_q <= '0;
            sum_q <= '0;
         end else if (state == RUN) begin
            sum_q[{idx_q, 3'b000} +: 8] <= add_s;
            cy_q                        <= add_carry;
            if (last_byte) begin
               cout_q <= add_carry;
            end else begin
               idx_q <= idx_q + IW'(1);
            end
         end
      end
   end

   // Handshake outputs come straight from the state register.
   assign bus.o_ready = (state == IDLE);
   assign bus.o_valid = (state == DONE);
   assign bus.o_busy  = (state != IDLE);
   assign bus.o_sum   = sum_q;
   assign bus.o_cout  = cout_q;
   assign dbg_state   = state;
endmodule

// File: tb/tb_ksa_byte_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ksa_byte_sequencer
//
// Directed bench for ksa_byte_sequencer at NBYTES = 4, 1 and 16 (three
// instances sharing clock and reset). Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_ksa_byte_sequencer;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ksa_byte_sequencer_if #(.NBYTES(4))  bus4 ();
   ksa_byte_sequencer_if #(.NBYTES(1))  bus1 ();
   ksa_byte_sequencer_if #(.NBYTES(16)) bus16 ();

   logic [1:0] st4;
   logic [1:0] st1;
   logic [1:0] st16;

   ksa_byte_sequencer #(.NBYTES(4)) dut4 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus4),
      .dbg_state (st4)
   );

   ksa_byte_sequencer #(.NBYTES(1)) dut1 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus1),
      .dbg_state (st1)
   );

   ksa_byte_sequencer #(.NBYTES(16)) dut16 (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .bus       (bus16),
      .dbg_state (st16)
   );

   // ---------------- scoreboard state ----------------
   int total;
   int bad;
   logic [32:0] exp_q[$];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- accessors (sel: 0=N4, 1=N1, 2=N16) ----------------
   function automatic logic f_valid(input int sel);
      case (sel)
         0:       return bus4.o_valid;
         1:       return bus1.o_valid;
         default: return bus16.o_valid;
      endcase
   endfunction

   function automatic logic f_ready(input int sel);
      case (sel)
         0:       return bus4.o_ready;
         1:       return bus1.o_ready;
         default: return bus16.o_ready;
      endcase
   endfunction

   function automatic logic f_busy(input int sel);
      case (sel)
         0:       return bus4.o_busy;
         1:       return bus1.o_busy;
         default: return bus16.o_busy;
      endcase
   endfunction

   function automatic logic f_cout(input int sel);
      case (sel)
         0:       return bus4.o_cout;
         1:       return bus1.o_cout;
         default: return bus16.o_cout;
      endcase
   endfunction

   function automatic logic [127:0] f_sum(input int sel);
      case (sel)
         0:       return {96'd0, bus4.o_sum};
         1:       return {120'd0, bus1.o_sum};
         default: return bus16.o_sum;
      endcase
   endfunction

   function automatic logic [1:0] f_state(input int sel);
      case (sel)
         0:       return st4;
         1:       return st1;
         default: return st16;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input int sel, input logic v, input logic [127:0] a,
                        input logic [127:0] b, input logic cin);
      case (sel)
         0: begin
            bus4.i_valid = v; bus4.i_a = a[31:0]; bus4.i_b = b[31:0]; bus4.i_cin = cin;
         end
         1: begin
            bus1.i_valid = v; bus1.i_a = a[7:0]; bus1.i_b = b[7:0]; bus1.i_cin = cin;
         end
         default: begin
            bus16.i_valid = v; bus16.i_a = a; bus16.i_b = b; bus16.i_cin = cin;
         end
      endcase
   endtask

   task automatic set_ready(input int sel, input logic r);
      case (sel)
         0:       bus4.i_ready = r;
         1:       bus1.i_ready = r;
         default: bus16.i_ready = r;
      endcase
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge: presents a request, lets the accept edge pass,
   // then withdraws it and scrambles the operand bus.
   task automatic issue(input int sel, input logic [127:0] a, input logic [127:0] b,
                        input logic cin);
      drive(sel, 1'b1, a, b, cin);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, ~a, ~b, ~cin);
   endtask

   // Counts rising edges after the accept edge until o_valid is seen.
   task automatic wait_done(input int sel, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!f_valid(sel) && lat < 40);
   endtask

   task automatic handshake(input string tag, input int sel);
      set_ready(sel, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_ready(sel, 1'b0);
      chk({tag, "_valid_drop"}, f_valid(sel), 1'b0);
      chk({tag, "_ready_back"}, f_ready(sel), 1'b1);
   endtask

   task automatic do_op(input string tag, input int sel, input logic [127:0] a,
                        input logic [127:0] b, input logic cin,
                        input logic [127:0] exp_sum, input logic exp_cout,
                        input int exp_lat);
      int lat;
      issue(sel, a, b, cin);
      chk({tag, "_busy"}, f_busy(sel), 1'b1);
      wait_done(sel, lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_sum"}, f_sum(sel), exp_sum);
      chk({tag, "_cout"}, f_cout(sel), exp_cout);
      handshake(tag, sel);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int          lat;
      int          acc;
      int          last_cyc;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [127:0] s128;
      logic [127:0] wa;
      logic [127:0] wb;
      logic         wc;
      logic [128:0] wref;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      for (int s = 0; s < 3; s++) begin
         drive(s, 1'b0, '0, '0, 1'b0);
         set_ready(s, 1'b0);
      end

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst_valid", f_valid(0), 1'b0);
      chk("rst_busy",  f_busy(0),  1'b0);
      chk("rst_sum",   f_sum(0),   128'd0);
      chk("rst_cout",  f_cout(0),  1'b0);
      chk("rst_ready", f_ready(0), 1'b1);
      chk("rst_state", f_state(0), 2'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic NBYTES=4 vectors
      do_op("t_ffff_p1",  0, 128'hFFFFFFFF, 128'h00000001, 1'b0, 128'h00000000, 1'b1, 4);
      do_op("t_1234",     0, 128'h12345678, 128'h11111111, 1'b1, 128'h2345678A, 1'b0, 4);
      do_op("t_8000",     0, 128'h80000000, 128'h80000000, 1'b0, 128'h00000000, 1'b1, 4);

      // Back-pressure: hold the result while a new request waits
      issue(0, 128'h0000FFFF, 128'h00000001, 1'b0);
      wait_done(0, lat);
      chk("bp_lat",  lat, 4);
      chk("bp_sum0", f_sum(0), 128'h00010000);
      chk("bp_cout0", f_cout(0), 1'b0);
      drive(0, 1'b1, 128'h00000001, 128'h00000002, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_hold_valid", f_valid(0), 1'b1);
         chk("bp_hold_ready", f_ready(0), 1'b0);
         chk("bp_hold_sum",   f_sum(0),   128'h00010000);
         chk("bp_hold_cout",  f_cout(0),  1'b0);
      end
      set_ready(0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_ready(0, 1'b0);
      chk("bp_idle_state", f_state(0), 2'd0);
      chk("bp_idle_valid", f_valid(0), 1'b0);
      chk("bp_idle_ready", f_ready(0), 1'b1);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 128'hDEADBEEF, 128'hCAFEF00D, 1'b1);
      chk("bp_new_run", f_state(0), 2'd1);
      wait_done(0, lat);
      chk("bp_new_lat",  lat, 4);
      chk("bp_new_sum",  f_sum(0), 128'h00000003);
      chk("bp_new_cout", f_cout(0), 1'b0);
      handshake("bp_new", 0);

      // Back-to-back with i_valid and i_ready held high
      acc      = 0;
      last_cyc = 0;
      set_ready(0, 1'b1);
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (f_valid(0)) begin
            s128 = f_sum(0);
            if (exp_q.size() == 0) begin
               chk("b2b_unexpected", {f_cout(0), s128[31:0]}, 128'd0);
            end else begin
               chk("b2b_result", {f_cout(0), s128[31:0]}, exp_q.pop_front());
            end
         end
         if (f_ready(0)) begin
            if (acc < 8) begin
               if (acc > 0) chk("b2b_gap", cyc - last_cyc, 6);
               last_cyc = cyc;
               ra = $urandom;
               rb = $urandom;
               rc = 1'($urandom_range(0, 1));
               drive(0, 1'b1, ra, rb, rc);
               exp_q.push_back(33'(ra) + 33'(rb) + 33'(rc));
               acc++;
            end else begin
               drive(0, 1'b0, '0, '0, 1'b0);
               break;
            end
         end else begin
            drive(0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
         end
         @(posedge clk);
         @(negedge clk);
      end
      set_ready(0, 1'b0);
      drive(0, 1'b0, '0, '0, 1'b0);
      chk("b2b_accepts", acc, 8);
      chk("b2b_drained", exp_q.size(), 0);
      @(negedge clk);

      // Asynchronous reset during the second RUN cycle
      issue(0, 128'h01010101, 128'h02020202, 1'b0);
      @(posedge clk);
      #2;
      chk("arst_pre_busy", f_busy(0), 1'b1);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", f_valid(0), 1'b0);
      chk("arst_sum",   f_sum(0),   128'd0);
      chk("arst_busy",  f_busy(0),  1'b0);
      chk("arst_state", f_state(0), 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("arst_ready", f_ready(0), 1'b1);
      do_op("arst_after", 0, 128'h00000005, 128'h00000003, 1'b0, 128'h00000008, 1'b0, 4);

      // NBYTES=1
      do_op("n1_ff",  1, 128'hFF, 128'h01, 1'b1, 128'h01, 1'b1, 1);
      do_op("n1_7f",  1, 128'h7F, 128'h80, 1'b0, 128'hFF, 1'b0, 1);

      // NBYTES=16: full-width carry ripple, then random sweep
      do_op("n16_ones", 2, {128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 16);
      for (int k = 0; k < 4; k++) begin
         wa   = {$urandom, $urandom, $urandom, $urandom};
         wb   = {$urandom, $urandom, $urandom, $urandom};
         wc   = 1'($urandom_range(0, 1));
         wref = 129'(wa) + 129'(wb) + 129'(wc);
         do_op("n16_rand", 2, wa, wb, wc, wref[127:0], wref[128], 16);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
